// File: rtl/spi_slave.sv
// spi_slave: SPI slave endpoint, 8-bit frames, modes 0-3, MSB/LSB-first.
// Define SPI_SLAVE_SDO_HIZ_EN to tri-state sdo while idle (shared MISO).
module spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       cpol,
  input  logic       cpha,
  input  logic       msb_lsb,
  input  logic [7:0] tx_data,
  input  logic       tx_wr,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy,
  input  logic       sck,
  input  logic       cs,
  input  logic       sdi,
  output logic       sdo
);
  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, sdi_sync;
  logic                   sck_d, cs_d;
  logic                   cpol_l, cpha_l, msb_l;
  logic [7:0]             tx_buf, tx_sh, rx_sh;
  logic [3:0]             bit_cnt;
  logic                   sdo_r;

  function automatic logic [7:0] rev8(input logic [7:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = d[7-i];
    return r;
  endfunction

  // Synchronize the asynchronous SPI pins and keep one extra delay for edge detection
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sck_sync <= '0;
      cs_sync  <= '1;
      sdi_sync <= '0;
      sck_d    <= 1'b0;
      cs_d     <= 1'b1;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs};
      sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], sdi};
      sck_d    <= sck_sync[SYNC_STAGES-1];
      cs_d     <= cs_sync[SYNC_STAGES-1];
    end
  end

  logic       sck_s, cs_s, sdi_s, sck_edge, lead, trail, samp, shft, cs_fall;
  logic [7:0] load_first, load_next;

  assign sck_s      = sck_sync[SYNC_STAGES-1];
  assign cs_s       = cs_sync[SYNC_STAGES-1];
  assign sdi_s      = sdi_sync[SYNC_STAGES-1];
  assign sck_edge   = sck_s ^ sck_d;
  assign lead       = sck_edge & (sck_s ^ cpol_l);
  assign trail      = sck_edge & ~(sck_s ^ cpol_l);
  assign samp       = cpha_l ? trail : lead;
  assign shft       = cpha_l ? lead : trail;
  assign cs_fall    = cs_d & ~cs_s;
  // TX shift register always emits bit 7 first, so LSB-first frames load bit-reversed
  assign load_first = msb_lsb ? tx_buf : rev8(tx_buf);
  assign load_next  = msb_l ? tx_buf : rev8(tx_buf);
  assign busy       = (state != IDLE);

  // TX buffer: host writes at any time, consumed at the next byte load
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) tx_buf <= 8'h00;
    else if (tx_wr) tx_buf <= tx_data;
  end

  // Frame FSM: latch mode at cs fall, sample/shift on sck edges, deliver byte in DONE
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cpol_l    <= 1'b0;
      cpha_l    <= 1'b0;
      msb_l     <= 1'b1;
      tx_sh     <= 8'h00;
      rx_sh     <= 8'h00;
      bit_cnt   <= 4'd0;
      sdo_r     <= 1'b0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: if (cs_fall) begin
          cpol_l  <= cpol;
          cpha_l  <= cpha;
          msb_l   <= msb_lsb;
          bit_cnt <= 4'd0;
          tx_sh   <= cpha ? load_first : load_first << 1;
          sdo_r   <= cpha ? 1'b0 : load_first[7];
          state   <= XFER;
        end
        XFER: if (cs_s) begin
          frame_err <= (bit_cnt != 4'd0);
          sdo_r     <= 1'b0;
          state     <= IDLE;
        end else begin
          if (samp) begin
            rx_sh   <= msb_l ? {rx_sh[6:0], sdi_s} : {sdi_s, rx_sh[7:1]};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) state <= DONE;
          end
          if (shft) begin
            sdo_r <= tx_sh[7];
            tx_sh <= tx_sh << 1;
          end
        end
        DONE: begin
          rx_data  <= rx_sh;
          rx_valid <= 1'b1;
          bit_cnt  <= 4'd0;
          // next byte's first bit goes out on the next shift edge, in every mode
          tx_sh    <= load_next;
          if (cs_s) sdo_r <= 1'b0;
          state    <= cs_s ? IDLE : XFER;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_SLAVE_SDO_HIZ_EN
  assign sdo = busy ? sdo_r : 1'bz;
`else
  assign sdo = busy ? sdo_r : 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed SPI master stimulus with an rx_valid scoreboard monitor.
module tb_spi_slave;
  localparam int H = 8;

  logic       clk = 1'b0, resetn = 1'b0;
  logic       cpol = 1'b0, cpha = 1'b0, msb_lsb = 1'b1, tx_wr = 1'b0;
  logic       sck = 1'b0, cs = 1'b1, sdi = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, busy, sdo;

  int         checks = 0, errors = 0, fe_cnt = 0, rv_cnt = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] mo[4], mi[4];
  logic       mid_wr = 1'b0;
  logic [7:0] mid_val = 8'h00;
  logic [7:0] idle_sdo;

  always #5 clk = ~clk;

  spi_slave #(.SYNC_STAGES(2)) dut (
    .clk(clk), .resetn(resetn), .cpol(cpol), .cpha(cpha), .msb_lsb(msb_lsb),
    .tx_data(tx_data), .tx_wr(tx_wr), .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_err(frame_err), .busy(busy), .sck(sck), .cs(cs), .sdi(sdi), .sdo(sdo)
  );

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] d);
    @(negedge clk);
    tx_data = d;
    tx_wr   = 1'b1;
    @(negedge clk);
    tx_wr   = 1'b0;
  endtask

  // Scoreboard monitor: every rx_valid pops one expected byte
  always @(negedge clk) begin
    if (rx_valid) begin
      rv_cnt++;
      if (exp_rx.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected: got %h expected no strobe", rx_data);
      end else chk("rx_data", rx_data, exp_rx.pop_front());
    end
    if (frame_err) fe_cnt++;
  end

  // Bit-level master: runs nbits sck cycles over mo[], collecting sdo into mi[]
  task automatic xfer(input logic p, input logic ph, input logic m, input int nbits, input logic keep);
    int bi, j, nb, nj;
    cpol = p; cpha = ph; msb_lsb = m; sck = p;
    for (int k = 0; k < 4; k++) mi[k] = 8'h00;
    cyc(4);
    if (!ph) sdi = mo[0][m ? 7 : 0];
    cs = 1'b0;
    cyc(H);
    chk("busy_in_frame", {7'b0, busy}, 8'h01);
    for (int i = 0; i < nbits; i++) begin
      bi = i / 8;
      j  = m ? 7 - (i % 8) : i % 8;
      sck = ~p;
      if (ph) sdi = mo[bi][j];
      else mi[bi][j] = sdo;
      if (mid_wr && i == 3) begin
        tx_data = mid_val;
        tx_wr = 1'b1;
        cyc(1);
        tx_wr = 1'b0;
        cyc(H - 1);
      end else cyc(H);
      sck = p;
      if (ph) mi[bi][j] = sdo;
      else if (i + 1 < nbits) begin
        nb = (i + 1) / 8;
        nj = m ? 7 - ((i + 1) % 8) : (i + 1) % 8;
        sdi = mo[nb][nj];
      end
      cyc(H);
    end
    if (!keep) begin
      cs = 1'b1;
      cyc(H + 4);
    end
  endtask

  int fe0, rv0;

  initial begin
`ifdef SPI_SLAVE_SDO_HIZ_EN
    idle_sdo = {7'b0, 1'bz};
`else
    idle_sdo = 8'h00;
`endif
    cyc(3);
    chk("reset_busy", {7'b0, busy}, 8'h00);
    resetn = 1'b1;
    cyc(3);
    chk("reset_rx_data", rx_data, 8'h00);
    chk("reset_rx_valid", {7'b0, rx_valid}, 8'h00);
    chk("reset_frame_err", {7'b0, frame_err}, 8'h00);
    chk("reset_busy", {7'b0, busy}, 8'h00);
    chk("idle_sdo", {7'b0, sdo}, idle_sdo);

    // mode 0, MSB-first
    wr(8'hA5);
    mo[0] = 8'h3C;
    exp_rx.push_back(8'h3C);
    xfer(1'b0, 1'b0, 1'b1, 8, 1'b0);
    chk("mode0_miso", mi[0], 8'hA5);
    chk("mode0_idle_busy", {7'b0, busy}, 8'h00);
    chk("mode0_idle_sdo", {7'b0, sdo}, idle_sdo);

    // modes 1..3, LSB-first, buffer reused across frames
    wr(8'h81);
    for (int md = 1; md < 4; md++) begin
      mo[0] = 8'h01;
      exp_rx.push_back(8'h01);
      xfer(md[1], md[0], 1'b0, 8, 1'b0);
      chk($sformatf("mode%0d_miso", md), mi[0], 8'h81);
    end

    // two bytes in one cs window, buffer rewritten during the first
    wr(8'h9A);
    mo[0] = 8'h12;
    mo[1] = 8'h34;
    exp_rx.push_back(8'h12);
    exp_rx.push_back(8'h34);
    mid_wr = 1'b1;
    mid_val = 8'h56;
    xfer(1'b0, 1'b0, 1'b1, 16, 1'b0);
    mid_wr = 1'b0;
    chk("b2b_miso0", mi[0], 8'h9A);
    chk("b2b_miso1", mi[1], 8'h56);

    // abort after 5 sck cycles
    fe0 = fe_cnt;
    rv0 = rv_cnt;
    mo[0] = 8'hFF;
    xfer(1'b0, 1'b0, 1'b1, 5, 1'b0);
    chk("abort_frame_err_pulses", 8'(fe_cnt - fe0), 8'd1);
    chk("abort_no_rx_valid", 8'(rv_cnt - rv0), 8'd0);
    chk("abort_rx_data_hold", rx_data, 8'h34);
    chk("abort_busy", {7'b0, busy}, 8'h00);

    // reset mid-frame after 3 bits
    wr(8'h77);
    mo[0] = 8'h00;
    rv0 = rv_cnt;
    xfer(1'b0, 1'b0, 1'b1, 3, 1'b1);
    resetn = 1'b0;
    cyc(1);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", {7'b0, rx_valid}, 8'h00);
    chk("rst_frame_err", {7'b0, frame_err}, 8'h00);
    chk("rst_busy", {7'b0, busy}, 8'h00);
    chk("rst_sdo", {7'b0, sdo}, idle_sdo);
    cs = 1'b1;
    sck = 1'b0;
    cyc(3);
    resetn = 1'b1;
    cyc(H);
    chk("rst_no_rx_valid", 8'(rv_cnt - rv0), 8'd0);
    chk("rst_busy_after", {7'b0, busy}, 8'h00);
    mo[0] = 8'hFF;
    exp_rx.push_back(8'hFF);
    xfer(1'b0, 1'b0, 1'b1, 8, 1'b0);
    chk("post_rst_miso", mi[0], 8'h00);
    chk("post_rst_rx_data", rx_data, 8'hFF);

    cyc(4);
    chk("scoreboard_drained", 8'(exp_rx.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
